char_rx_p: RTL and testbench

CHAR_RX_P -- requirements
Module: char_rx_p

---
 rtl/char_rx_p.sv | 256 +++++++++++++++++++++++++
 tb/tb_char_rx_p.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/char_rx_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | char_rx_p : oversampled asynchronous serial character receiver with       |
// |             optional parity, 1/2 stop bits and a one-deep holding output. |
// | Optional feature macro: CHAR_RX_MAJ3_EN (2-of-3 majority bit decision).   |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
module char_rx_p #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic [15:0]       div,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic              rx,
  input  logic              ack,
  output logic [DATA_W-1:0] char,
  output logic              valid,
  output logic              par_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int c_SMP_W = $clog2(OVS + 4);
  localparam int c_BIT_W = $clog2(DATA_W + 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);

  // Decision point is the tick count since the last bit centre; majority mode
  // decides one tick after the centre, so the next bit restarts counting at 1.
`ifdef CHAR_RX_MAJ3_EN
  localparam logic [c_SMP_W-1:0] c_START_DEC = c_SMP_W'(OVS / 2 + 1);
  localparam logic [c_SMP_W-1:0] c_BIT_DEC   = c_SMP_W'(OVS + 1);
  localparam logic [c_SMP_W-1:0] c_RELOAD    = c_SMP_W'(1);
`else
  localparam logic [c_SMP_W-1:0] c_START_DEC = c_SMP_W'(OVS / 2);
  localparam logic [c_SMP_W-1:0] c_BIT_DEC   = c_SMP_W'(OVS);
  localparam logic [c_SMP_W-1:0] c_RELOAD    = c_SMP_W'(0);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rx_s1;
  logic                r_rx_s2;
  logic [15:0]         r_tick_cnt;
  logic [15:0]         r_div;
  logic [c_SMP_W-1:0]  r_smp_cnt;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par_acc;
  logic                r_perr;
  logic                r_ferr;
  logic [1:0]          r_par_mode;
  logic                r_stop2;
  logic [DATA_W-1:0]   r_char;
  logic                r_valid;
  logic                r_par_err;
  logic                r_frame_err;
  logic                r_overrun;

  logic                w_rx;
  logic                w_tick;
  logic [c_SMP_W-1:0]  w_smp_n;
  logic [c_SMP_W-1:0]  w_dec_pt;
  logic                w_dec;
  logic                w_bit;
  logic                w_start;
  logic                w_done;
  logic                w_par_en;
  logic                w_par_exp;
  logic                w_ferr_final;

  assign w_rx     = r_rx_s2;
  assign w_tick   = (r_tick_cnt == r_div);
  assign w_smp_n  = r_smp_cnt + c_SMP_W'(1);
  assign w_dec_pt = (r_state == S_START) ? c_START_DEC : c_BIT_DEC;
  assign w_dec    = w_tick && (r_state != S_IDLE) && (w_smp_n == w_dec_pt);
  assign w_par_en = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
  assign w_par_exp    = (r_par_mode == 2'b10) ? ~r_par_acc : r_par_acc;
  assign w_ferr_final = r_ferr | ~w_bit;

`ifdef CHAR_RX_MAJ3_EN
  logic [1:0] r_maj;

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_maj <= 2'b11;
    end else if (w_tick && ((w_smp_n + c_SMP_W'(2)) == w_dec_pt)) begin
      r_maj[0] <= w_rx;
    end else if (w_tick && ((w_smp_n + c_SMP_W'(1)) == w_dec_pt)) begin
      r_maj[1] <= w_rx;
    end
  end

  assign w_bit = (r_maj[0] & r_maj[1]) | (r_maj[0] & w_rx) | (r_maj[1] & w_rx);
`else
  assign w_bit = w_rx;
`endif

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // The divisor is captured only at a wrap so a mid-period change cannot skip a tick.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_div      <= '0;
    end else if (w_start || w_tick) begin
      r_tick_cnt <= '0;
      r_div      <= div;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_state_nxt = S_START;
          w_start     = 1'b1;
        end
      end
      S_START: begin
        if (w_dec) w_state_nxt = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_dec && (r_bit_cnt == c_LAST_BIT)) w_state_nxt = w_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_dec) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_dec && (!r_stop2 || (r_bit_cnt != '0))) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_smp_cnt <= '0;
    end else if (w_start) begin
      r_smp_cnt <= '0;
    end else if (w_dec) begin
      r_smp_cnt <= c_RELOAD;
    end else if (w_tick) begin
      r_smp_cnt <= w_smp_n;
    end
  end

  // Bit counter indexes data bits, then is reused to count stop bits.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_bit_cnt <= '0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
    end else if (w_dec) begin
      if (r_state == S_DATA) begin
        r_bit_cnt <= (r_bit_cnt == c_LAST_BIT) ? '0 : r_bit_cnt + c_BIT_W'(1);
      end else if (r_state == S_STOP) begin
        r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_par_mode <= 2'b00;
      r_stop2    <= 1'b0;
    end else if (w_start) begin
      r_par_acc  <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_par_mode <= par_mode;
      r_stop2    <= stop2;
    end else if (w_dec) begin
      case (r_state)
        S_DATA: begin
          r_shift   <= {w_bit, r_shift[DATA_W-1:1]};
          r_par_acc <= r_par_acc ^ w_bit;
        end
        S_PARITY: r_perr <= (w_bit != w_par_exp);
        S_STOP:   r_ferr <= w_ferr_final;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_char      <= '0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_done && (!r_valid || ack)) begin
      r_char      <= r_shift;
      r_valid     <= 1'b1;
      r_par_err   <= r_perr;
      r_frame_err <= w_ferr_final;
      r_overrun   <= 1'b0;
    end else if (w_done) begin
      r_overrun   <= 1'b1;
    end else if (ack && r_valid) begin
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign char      = r_char;
  assign valid     = r_valid;
  assign par_err   = r_par_err;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_char_rx_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_char_rx_p : directed self-checking bench for char_rx_p (8 bits, OVS 16)|
// | Revision     : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_char_rx_p;

  logic        sclk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic [1:0]  par_mode;
  logic        stop2;
  logic        rx;
  logic        ack;
  logic [7:0]  char;
  logic        valid;
  logic        par_err;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int   total = 0;
  int   bad = 0;
  int   bitlen = 16;
  int   cyc = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;
  int   t0;
  int   lat;
  int   waited;

  char_rx_p #(.DATA_W(8), .OVS(16)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .div       (div),
    .par_mode  (par_mode),
    .stop2     (stop2),
    .rx        (rx),
    .ack       (ack),
    .char      (char),
    .valid     (valid),
    .par_err   (par_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) begin
    if (valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= valid;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds one bit for bitlen cycles; optional one-cycle inversion at the bit centre.
  task automatic send_bit(input logic b, input logic glitch);
    rx = b;
    if (glitch) begin
      repeat (bitlen / 2) @(negedge sclk);
      rx = ~b;
      @(negedge sclk);
      rx = b;
      repeat (bitlen / 2 - 1) @(negedge sclk);
    end else begin
      repeat (bitlen) @(negedge sclk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                            input int nstop, input logic [1:0] stops, input logic glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    if (has_par) send_bit(par_bit, 1'b0);
    for (int s = 0; s < nstop; s++) send_bit(stops[s], 1'b0);
    rx = 1'b1;
    repeat (bitlen) @(negedge sclk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge sclk);
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; div = 16'd0; par_mode = 2'b00; stop2 = 1'b0; rx = 1'b1; ack = 1'b0;
    repeat (4) @(negedge sclk);
    rst = 1'b0;
    check("rst_char", char, 16'h00);
    check("rst_valid", valid, 0);
    check("rst_par_err", par_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    repeat (4) @(negedge sclk);

    // Basic 8N1 frame and its latency from the start edge
    t0 = cyc;
    send_frame(8'h41, 1'b0, 1'b0, 1, 2'b01, 1'b0);
    lat = rise_cyc - t0;
    check("latency_155pm1", (lat >= 154) && (lat <= 156), 1);
    check("basic_char", char, 16'h41);
    check("basic_valid", valid, 1);
    check("basic_par_err", par_err, 0);
    check("basic_frame_err", frame_err, 0);
    check("basic_busy_idle", busy, 0);
    pulse_ack();
    check("ack_valid", valid, 0);
    check("ack_char_kept", char, 16'h41);

    // Even and odd parity
    par_mode = 2'b01;
    send_frame(8'h41, 1'b1, 1'b1, 1, 2'b01, 1'b0);
    check("even_bad_char", char, 16'h41);
    check("even_bad_perr", par_err, 1);
    pulse_ack();
    check("ack_clears_perr", par_err, 0);
    send_frame(8'h41, 1'b1, 1'b0, 1, 2'b01, 1'b0);
    check("even_ok_valid", valid, 1);
    check("even_ok_perr", par_err, 0);
    pulse_ack();
    par_mode = 2'b10;
    send_frame(8'h41, 1'b1, 1'b1, 1, 2'b01, 1'b0);
    check("odd_ok_perr", par_err, 0);
    pulse_ack();
    send_frame(8'h41, 1'b1, 1'b0, 1, 2'b01, 1'b0);
    check("odd_bad_perr", par_err, 1);
    pulse_ack();
    par_mode = 2'b00;

    // Stop bit low
    send_frame(8'h5A, 1'b0, 1'b0, 1, 2'b00, 1'b0);
    check("ferr_valid", valid, 1);
    check("ferr_char", char, 16'h5A);
    check("ferr_flag", frame_err, 1);
    check("ferr_perr", par_err, 0);
    pulse_ack();
    check("ack_clears_ferr", frame_err, 0);

    // Two stop bits
    stop2 = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, 2, 2'b01, 1'b0);
    check("stop2_char", char, 16'h3C);
    check("stop2_second_low", frame_err, 1);
    pulse_ack();
    send_frame(8'hC3, 1'b0, 1'b0, 2, 2'b11, 1'b0);
    check("stop2_ok_char", char, 16'hC3);
    check("stop2_ok_ferr", frame_err, 0);
    pulse_ack();
    stop2 = 1'b0;

    // False start: 4 ticks low
    rx = 1'b0;
    repeat (4) @(negedge sclk);
    rx = 1'b1;
    check("fs_busy_start", busy, 1);
    waited = 0;
    while (busy && waited < 11) begin
      @(negedge sclk);
      waited++;
    end
    check("fs_busy_cleared", busy, 0);
    check("fs_no_valid", valid, 0);
    check("fs_char_kept", char, 16'hC3);
    repeat (16) @(negedge sclk);

    // Overrun
    send_frame(8'h11, 1'b0, 1'b0, 1, 2'b01, 1'b0);
    check("ovr_first_no_ovr", overrun, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1, 2'b01, 1'b0);
    check("ovr_char_kept", char, 16'h11);
    check("ovr_valid", valid, 1);
    check("ovr_flag", overrun, 1);
    pulse_ack();
    check("ovr_ack_valid", valid, 0);
    check("ovr_ack_flag", overrun, 0);

    // Reset during data bit 3 of 0x33
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rx = 1'b0;
    repeat (8) @(negedge sclk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge sclk);
    rst = 1'b0;
    repeat (32) @(negedge sclk);
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    check("abort_char", char, 16'h00);
    send_frame(8'h44, 1'b0, 1'b0, 1, 2'b01, 1'b0);
    check("resume_char", char, 16'h44);
    check("resume_valid", valid, 1);
    pulse_ack();

    // Divisor 1: one tick every 2 cycles
    div = 16'd1;
    bitlen = 32;
    repeat (8) @(negedge sclk);
    send_frame(8'h96, 1'b0, 1'b0, 1, 2'b01, 1'b0);
    check("div1_char", char, 16'h96);
    check("div1_ferr", frame_err, 0);
    pulse_ack();
    div = 16'd0;
    bitlen = 16;
    repeat (8) @(negedge sclk);

`ifdef CHAR_RX_MAJ3_EN
    send_frame(8'h44, 1'b0, 1'b0, 1, 2'b01, 1'b1);
    check("maj_glitch_char", char, 16'h44);
    check("maj_glitch_valid", valid, 1);
    check("maj_glitch_ferr", frame_err, 0);
    pulse_ack();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
